lsu_ctrl: RTL

Load/store unit controller sitting between the CPU execute stage and the data memory port. Accepts one load or store request at a time over a valid/ready handshake and drives the data-memory initiator signals: `mem_read`, `mem_write`, `sign_extend`, `size`, `addr` and `write_data`. Captures `read_data` after a fixed read latency and returns the result or error over a valid/ready response channel. Optionally splits misaligned accesses into sequential byte accesses.

---
 rtl/lsu_ctrl_if.sv | 38 +++
 rtl/lsu_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: request/response handshake plus data-memory initiator bus.
// slave = controller view, master = CPU/memory environment view.
interface lsu_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_read;
  logic        mem_write;
  logic        sign_extend;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned,
    input  req_addr, req_wdata, rsp_ready, read_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_read, mem_write, sign_extend, size,
    output addr, write_data
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned,
    output req_addr, req_wdata, rsp_ready, read_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_read, mem_write, sign_extend, size,
    input  addr, write_data
  );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: one-at-a-time load/store controller, execute stage to dmem.
// Ports: clk, rst_n (sync, active low), bus (lsu_ctrl_if.slave: req/rsp
// handshakes, mem strobes/addr/size/data). Option: LSU_MISALIGN_SPLIT_EN
// splits misaligned half/word accesses into byte beats.
module lsu_ctrl #(
  parameter int unsigned RD_LAT = 1
) (
  input logic       clk,
  input logic       rst_n,
  lsu_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, RESP
  } state_e;

  localparam logic [2:0] CntLast = 3'(RD_LAT - 1);

  state_e      state_q;
  logic        we_q;
  logic        err_q;
  logic        rd_q;
  logic        wr_q;
  logic        sext_q;
  logic [1:0]  msize_q;
  logic [2:0]  cnt_q;
  logic [31:0] rdata_q;
  logic [31:0] maddr_q;
  logic [31:0] mwdata_q;
  logic        misal;
  logic        bad;

  assign misal =
    (bus.req_size == 2'b01 && bus.req_addr[0]) ||
    (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);

`ifdef LSU_MISALIGN_SPLIT_EN
  logic        split_q;
  logic        uns_q;
  logic [1:0]  rsize_q;
  logic [1:0]  beat_q;
  logic [1:0]  beat_n;
  logic [1:0]  beat_last;
  logic [31:0] raddr_q;
  logic [31:0] wdata_q;
  logic [31:0] baddr_n;
  logic [31:0] bdata_n;
  logic [31:0] asm_d;
  logic [31:0] ext_d;

  assign bad       = (bus.req_size == 2'b11);
  assign beat_n    = beat_q + 2'd1;
  assign beat_last = (rsize_q == 2'b10) ? 2'd3 : 2'd1;
  assign baddr_n   = raddr_q + {30'b0, beat_n};
  assign bdata_n   = {24'b0, 8'(wdata_q >> {beat_n, 3'b000})};

  // byte beat k lands in result byte k; extension once all bytes are in
  always_comb begin
    asm_d = rdata_q;
    asm_d[{beat_q, 3'b000} +: 8] = bus.read_data[7:0];
    ext_d = asm_d;
    if (rsize_q == 2'b01)
      ext_d = {{16{asm_d[15] & ~uns_q}}, asm_d[15:0]};
  end
`else
  assign bad = (bus.req_size == 2'b11) || misal;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      sext_q   <= 1'b0;
      msize_q  <= 2'b00;
      cnt_q    <= 3'd0;
      rdata_q  <= '0;
      maddr_q  <= '0;
      mwdata_q <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_q  <= 1'b0;
      uns_q    <= 1'b0;
      rsize_q  <= 2'b00;
      beat_q   <= 2'd0;
      raddr_q  <= '0;
      wdata_q  <= '0;
`endif
    end else begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            err_q   <= bad;
            rdata_q <= '0;
            cnt_q   <= 3'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_q <= misal;
            uns_q   <= bus.req_unsigned;
            rsize_q <= bus.req_size;
            beat_q  <= 2'd0;
            raddr_q <= bus.req_addr;
            wdata_q <= bus.req_wdata;
`endif
            if (bad) begin
              state_q <= RESP;
            end else begin
              state_q  <= ISSUE;
              rd_q     <= ~bus.req_we;
              wr_q     <= bus.req_we;
              maddr_q  <= bus.req_addr;
              msize_q  <= bus.req_size;
              sext_q   <= ~bus.req_we & ~bus.req_unsigned;
              mwdata_q <= bus.req_wdata;
`ifdef LSU_MISALIGN_SPLIT_EN
              if (misal) begin
                msize_q  <= 2'b00;
                sext_q   <= 1'b0;
                mwdata_q <= {24'b0, bus.req_wdata[7:0]};
              end
`endif
            end
          end
        end
        ISSUE: begin
          if (!we_q) begin
            state_q <= WAIT;
`ifdef LSU_MISALIGN_SPLIT_EN
          end else if (split_q && beat_q != beat_last) begin
            beat_q   <= beat_n;
            wr_q     <= 1'b1;
            maddr_q  <= baddr_n;
            mwdata_q <= bdata_n;
`endif
          end else begin
            state_q <= RESP;
          end
        end
        WAIT: begin
          if (cnt_q != CntLast) begin
            cnt_q <= cnt_q + 3'd1;
`ifdef LSU_MISALIGN_SPLIT_EN
          end else if (split_q && beat_q != beat_last) begin
            rdata_q <= asm_d;
            beat_q  <= beat_n;
            cnt_q   <= 3'd0;
            rd_q    <= 1'b1;
            maddr_q <= baddr_n;
            state_q <= ISSUE;
          end else if (split_q) begin
            rdata_q <= ext_d;
            state_q <= RESP;
`endif
          end else begin
            rdata_q <= bus.read_data;
            state_q <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready)
            state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready   = (state_q == IDLE);
  assign bus.rsp_valid   = (state_q == RESP);
  assign bus.rsp_rdata   = rdata_q;
  assign bus.rsp_err     = err_q;
  assign bus.mem_read    = rd_q;
  assign bus.mem_write   = wr_q;
  assign bus.sign_extend = sext_q;
  assign bus.size        = msize_q;
  assign bus.addr        = maddr_q;
  assign bus.write_data  = mwdata_q;
endmodule
